uart_frame_parser: RTL

Framing stage directly downstream of the UART receiver in the sensor interface. Consumes the receiver's byte stream, which is a one-cycle `valid` pulse per byte with no backpressure. Hunts for a start-of-frame byte, then captures command, length and payload and checks an 8-bit two's-complement checksum. Good frames are replayed on a ready/valid stream to the command/sensor logic, and every frame outcome is reported as a one-cycle status pulse.

---
 rtl/uart_frame_parser.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// Byte-stream framer: SOF, CMD, LEN, payload, CSUM -> ready/valid replay plus status pulses.
// Optional inter-byte timeout built only when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_parser #(
   parameter int unsigned CLK_FREQ      = 100_000_000,
   parameter int unsigned BAUD_RATE     = 115_200,
   parameter int unsigned MAX_LEN       = 16,
   parameter logic [7:0]  SOF           = 8'hA5,
   parameter int unsigned TIMEOUT_BYTES = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   in_data,
   input  logic                         in_valid,
   output logic [7:0]                   m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         m_last,
   output logic [7:0]                   cmd_out,
   output logic [$clog2(MAX_LEN+1)-1:0] len_out,
   output logic                         frame_ok,
   output logic                         err_csum,
   output logic                         err_len,
   output logic                         err_timeout,
   output logic                         err_drop
);

   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_LEN,
      S_PAYLOAD,
      S_CSUM,
      S_OUT
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    sum;
   logic [7:0]    cmd_reg;
   logic [LW-1:0] len_reg;
   logic [LW-1:0] idx;
   logic [LW-1:0] beat;
   logic [LW-1:0] beat_m1;
   logic [7:0]    buffer [MAX_LEN];

   logic ok_nxt, csum_nxt, len_nxt, to_nxt, drop_nxt;
   logic len_bad, last_pl, csum_good, fire, beat_last, timeout_hit, is_sof;

   assign is_sof    = (in_data == SOF);
   assign len_bad   = 32'(in_data) > MAX_LEN;
   assign last_pl   = (idx == len_reg - LW'(1));
   assign csum_good = (8'(sum + in_data) == 8'h00);
   assign fire      = m_valid && m_ready;
   assign beat_last = (beat == len_reg);
   assign beat_m1   = beat - LW'(1);
   assign cmd_out   = cmd_reg;
   assign len_out   = len_reg;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int unsigned TCYC = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
   localparam int unsigned TW   = $clog2(TCYC + 1);

   logic [TW-1:0] tcnt;
   logic          busy;

   assign busy        = (state == S_CMD) || (state == S_LEN) ||
                        (state == S_PAYLOAD) || (state == S_CSUM);
   assign timeout_hit = busy && !in_valid && (tcnt == TW'(TCYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tcnt <= '0;
      else if (!busy || in_valid || timeout_hit)
         tcnt <= '0;
      else
         tcnt <= tcnt + TW'(1);
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ok_nxt    = 1'b0;
      csum_nxt  = 1'b0;
      len_nxt   = 1'b0;
      to_nxt    = 1'b0;
      drop_nxt  = 1'b0;
      m_valid   = (state == S_OUT);
      m_last    = (state == S_OUT) && beat_last;
      m_data    = '0;
      if (state == S_OUT)
         m_data = (beat == '0) ? cmd_reg : buffer[beat_m1[IW-1:0]];

      if (timeout_hit) begin
         state_nxt = S_IDLE;
         to_nxt    = 1'b1;
      end else begin
         case (state)
            S_IDLE:
               if (in_valid && is_sof) state_nxt = S_CMD;
            S_CMD:
               if (in_valid) state_nxt = S_LEN;
            S_LEN:
               if (in_valid) begin
                  if (len_bad) begin
                     state_nxt = S_IDLE;
                     len_nxt   = 1'b1;
                  end else if (in_data == 8'h00) begin
                     state_nxt = S_CSUM;
                  end else begin
                     state_nxt = S_PAYLOAD;
                  end
               end
            S_PAYLOAD:
               if (in_valid && last_pl) state_nxt = S_CSUM;
            S_CSUM:
               if (in_valid) begin
                  if (csum_good) begin
                     state_nxt = S_OUT;
                     ok_nxt    = 1'b1;
                  end else begin
                     state_nxt = S_IDLE;
                     csum_nxt  = 1'b1;
                  end
               end
            S_OUT: begin
               // Input bytes cannot be stalled, so anything arriving during replay is lost.
               drop_nxt = in_valid;
               if (fire && beat_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         frame_ok    <= 1'b0;
         err_csum    <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         err_drop    <= 1'b0;
      end else begin
         state       <= state_nxt;
         frame_ok    <= ok_nxt;
         err_csum    <= csum_nxt;
         err_len     <= len_nxt;
         err_timeout <= to_nxt;
         err_drop    <= drop_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum     <= '0;
         idx     <= '0;
         cmd_reg <= '0;
         len_reg <= '0;
         beat    <= '0;
      end else begin
         if (in_valid) begin
            case (state)
               S_IDLE:
                  if (is_sof) begin
                     sum <= '0;
                     idx <= '0;
                  end
               S_CMD: begin
                  cmd_reg <= in_data;
                  sum     <= sum + in_data;
               end
               S_LEN:
                  if (!len_bad) begin
                     len_reg <= in_data[LW-1:0];
                     sum     <= sum + in_data;
                  end
               S_PAYLOAD: begin
                  idx <= idx + LW'(1);
                  sum <= sum + in_data;
               end
               S_CSUM:
                  beat <= '0;
               default: ;
            endcase
         end
         if (fire)
            beat <= beat + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_PAYLOAD && in_valid)
         buffer[idx[IW-1:0]] <= in_data;
   end

endmodule
